// File: rtl/jtag_master_seq_pkg.sv
// Shared encodings for the JTAG master sequencer: command codes, FSM states
// and the fixed TMS prefix/postfix step counts.
package jtag_master_seq_pkg;

    typedef enum logic [1:0] {
        JM_CMD_RESET = 2'b00,
        JM_CMD_IR    = 2'b01,
        JM_CMD_DR    = 2'b10,
        JM_CMD_IDLE  = 2'b11
    } jm_cmd_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_PRE     = 3'd2,
        S_IDLECYC = 3'd3,
        S_SHIFT   = 3'd4,
        S_POST    = 3'd5,
        S_DONE    = 3'd6
    } jm_state_e;

    localparam int unsigned IR_PRE_LEN = 4;  // SelDR, SelIR, CapIR, ShiftIR
    localparam int unsigned DR_PRE_LEN = 3;  // SelDR, CapDR, ShiftDR
    localparam int unsigned POST_LEN   = 2;  // Update, Run-Test/Idle
    localparam int unsigned RESET_LEN  = 6;  // five TMS=1 then one TMS=0

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: CLK_DIV clk low then CLK_DIV clk high per step, with one-clk
// pulses marking the falling edge (update TMS/TDI) and the pre-rise sample point.
module jtag_tck_gen #(
    parameter int unsigned CLK_DIV = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    output logic o_tck,
    output logic o_fall_pulse,
    output logic o_sample_pulse
);

    logic [7:0] r_cnt;
    logic       r_tck;
    logic       w_wrap;

    assign w_wrap = (r_cnt == 8'(CLK_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst || !i_enable) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_tck <= ~r_tck;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_tck          = r_tck;
    assign o_fall_pulse   = i_enable &&  r_tck && w_wrap;
    assign o_sample_pulse = i_enable && !r_tck && w_wrap;

endmodule

// File: rtl/jtag_master_seq.sv
// JTAG master: turns one parallel command at a time into a TCK/TMS/TDI walk of
// the TAP state machine and returns the TDO bits captured while shifting.
module jtag_master_seq
    import jtag_master_seq_pkg::*;
#(
    parameter int unsigned CLK_DIV = 5,
    parameter int unsigned MAX_LEN = 40,
    parameter int unsigned LEN_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [1:0]         req_cmd_i,
    input  logic [LEN_W-1:0]   req_len_i,
    input  logic [MAX_LEN-1:0] req_data_i,
    output logic               resp_valid_o,
    input  logic               resp_ready_i,
    output logic [MAX_LEN-1:0] resp_data_o,
    output logic               resp_err_o,
    output logic               busy_o,
    output logic               jtag_TCK_o,
    output logic               jtag_TMS_o,
    output logic               jtag_TDI_o,
    input  logic               jtag_TDO_i
);

    localparam int unsigned STEP_W = LEN_W + 1;
    localparam logic [MAX_LEN-1:0] BIT0 = {{(MAX_LEN-1){1'b0}}, 1'b1};

    jm_state_e          r_state, w_state_nxt;
    jm_cmd_e            r_cmd, w_req_cmd, w_cmd_eff;
    logic [LEN_W-1:0]   r_len;
    logic [MAX_LEN-1:0] r_data, r_tdo, w_step_sel;
    logic [STEP_W-1:0]  r_step, w_step_nxt, w_phase_len, w_len_ext;
    logic               r_err, r_tms, r_tdi, r_ready_en;
    logic               w_accept, w_len_bad, w_last, w_tms_nxt, w_tdi_nxt;
    logic               w_tck_en, w_tck, w_fall, w_sample, w_resp_valid;

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .clk            (clk),
        .rst            (rst),
        .i_enable       (w_tck_en),
        .o_tck          (w_tck),
        .o_fall_pulse   (w_fall),
        .o_sample_pulse (w_sample)
    );

    assign w_req_cmd  = jm_cmd_e'(req_cmd_i);
    assign w_accept   = req_valid_i && req_ready_o;
    assign w_cmd_eff  = w_accept ? w_req_cmd : r_cmd;
    assign w_len_ext  = {1'b0, r_len};
    assign w_step_sel = BIT0 << r_step;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_len_bad = 1'b0;
        case (w_req_cmd)
            JM_CMD_IR, JM_CMD_DR: w_len_bad = (req_len_i == '0) || (req_len_i > LEN_W'(MAX_LEN));
            JM_CMD_IDLE:          w_len_bad = (req_len_i == '0);
            default:              w_len_bad = 1'b0;
        endcase
    end

    always_comb begin
        w_phase_len = STEP_W'(1);
        case (r_state)
            S_RESET:           w_phase_len = STEP_W'(RESET_LEN);
            S_PRE:             w_phase_len = (r_cmd == JM_CMD_IR) ? STEP_W'(IR_PRE_LEN) : STEP_W'(DR_PRE_LEN);
            S_SHIFT, S_IDLECYC: w_phase_len = w_len_ext;
            S_POST:            w_phase_len = STEP_W'(POST_LEN);
            default:           w_phase_len = STEP_W'(1);
        endcase
    end

    assign w_last     = (r_step == w_phase_len - STEP_W'(1));
    assign w_step_nxt = (w_accept || w_last) ? '0 : r_step + STEP_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: each TCK phase ends on the falling edge of its last step
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_len_bad)                    w_state_nxt = S_DONE;
                    else if (w_req_cmd == JM_CMD_RESET) w_state_nxt = S_RESET;
                    else if (w_req_cmd == JM_CMD_IDLE)  w_state_nxt = S_IDLECYC;
                    else                              w_state_nxt = S_PRE;
                end
            end
            S_RESET:   if (w_fall && w_last) w_state_nxt = S_DONE;
            S_PRE:     if (w_fall && w_last) w_state_nxt = S_SHIFT;
            S_SHIFT:   if (w_fall && w_last) w_state_nxt = S_POST;
            S_POST:    if (w_fall && w_last) w_state_nxt = S_DONE;
            S_IDLECYC: if (w_fall && w_last) w_state_nxt = S_DONE;
            S_DONE:    if (resp_ready_i)     w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_resp_valid = (r_state == S_DONE);
        busy_o       = (r_state != S_IDLE);
        req_ready_o  = (r_state == S_IDLE) && !w_resp_valid && r_ready_en;
        w_tck_en     = (r_state == S_RESET) || (r_state == S_PRE) || (r_state == S_SHIFT) ||
                       (r_state == S_POST)  || (r_state == S_IDLECYC);
    end

    // TMS/TDI for the step that starts after this edge, in the state it starts in
    always_comb begin
        w_tms_nxt = 1'b0;
        case (w_state_nxt)
            S_RESET: w_tms_nxt = (w_step_nxt < STEP_W'(RESET_LEN - 1));
            S_PRE:   w_tms_nxt = (w_step_nxt == '0) ||
                                 ((w_cmd_eff == JM_CMD_IR) && (w_step_nxt == STEP_W'(1)));
            S_SHIFT: w_tms_nxt = (w_step_nxt == w_len_ext - STEP_W'(1));
            S_POST:  w_tms_nxt = (w_step_nxt == '0);
            default: w_tms_nxt = 1'b0;
        endcase
        w_tdi_nxt = (w_state_nxt == S_SHIFT) ? |(r_data & (BIT0 << w_step_nxt)) : 1'b1;
    end

    // NOTE: the request and capture registers are plain flops, so they are reset along with the control.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cmd      <= JM_CMD_RESET;
            r_len      <= '0;
            r_data     <= '0;
            r_step     <= '0;
            r_tdo      <= '0;
            r_err      <= 1'b0;
            r_tms      <= 1'b1;
            r_tdi      <= 1'b1;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_accept) begin
                r_cmd  <= w_req_cmd;
                r_len  <= req_len_i;
                r_data <= req_data_i;
                r_tdo  <= '0;
                r_err  <= w_len_bad;
            end else if (w_sample && (r_state == S_SHIFT) && jtag_TDO_i) begin
                r_tdo <= r_tdo | w_step_sel;
            end
            if (w_accept || w_fall) begin
                r_step <= w_step_nxt;
                r_tms  <= w_tms_nxt;
                r_tdi  <= w_tdi_nxt;
            end
        end
    end

    assign resp_valid_o = w_resp_valid;
    assign resp_data_o  = r_tdo;
    assign resp_err_o   = r_err;
    assign jtag_TCK_o   = w_tck;
    assign jtag_TMS_o   = r_tms;
    assign jtag_TDI_o   = r_tdi;

endmodule

// File: tb/tb_jtag_master_seq.sv
// Randomized bench for jtag_master_seq: a step-list model of each command
// predicts the TMS/TDI walk, TCK count, latency and captured TDO.
module tb_jtag_master_seq;
    import jtag_master_seq_pkg::*;

    localparam int CLK_DIV = 5;
    localparam int MAX_LEN = 40;
    localparam int LEN_W   = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [1:0]         req_cmd = 2'b00;
    logic [LEN_W-1:0]   req_len = '0;
    logic [MAX_LEN-1:0] req_data = '0;
    logic               resp_valid;
    logic               resp_ready = 1'b0;
    logic [MAX_LEN-1:0] resp_data;
    logic               resp_err;
    logic               busy;
    logic               tck, tms, tdi, tdo;

    jtag_master_seq #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_cmd_i    (req_cmd),
        .req_len_i    (req_len),
        .req_data_i   (req_data),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .resp_err_o   (resp_err),
        .busy_o       (busy),
        .jtag_TCK_o   (tck),
        .jtag_TMS_o   (tms),
        .jtag_TDI_o   (tdi),
        .jtag_TDO_i   (tdo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // TCK monitor: log TMS/TDI and time at every rising edge
    int rise_total = 0;
    bit tms_log [0:8191];
    bit tdi_log [0:8191];
    int rise_t  [0:8191];
    always @(posedge tck) begin
        if (rise_total < 8192) begin
            tms_log[rise_total] <= tms;
            tdi_log[rise_total] <= tdi;
            rise_t[rise_total]  <= int'($time);
        end
        rise_total <= rise_total + 1;
    end

    // TDO for step n of the current command is tdo_pat[n]
    int          cmd_base = 0;
    logic [63:0] tdo_pat  = '0;
    assign tdo = tdo_pat[6'(rise_total - cmd_base)];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Command as a list of TCK steps: TMS per step, where shifting starts, legality
    function automatic void model(input logic [1:0] cmd, input int len, output int n,
                                  output logic [63:0] tms_v, output int sh, output bit bad);
        n     = 0;
        tms_v = '0;
        sh    = 0;
        bad   = ((cmd == JM_CMD_IR || cmd == JM_CMD_DR) && (len == 0 || len > MAX_LEN)) ||
                (cmd == JM_CMD_IDLE && len == 0);
        if (bad) return;
        case (cmd)
            JM_CMD_RESET: begin
                for (int i = 0; i < 6; i++) begin
                    tms_v[n] = (i < 5);
                    n++;
                end
            end
            JM_CMD_IR, JM_CMD_DR: begin
                tms_v[0] = 1'b1;
                if (cmd == JM_CMD_IR) begin
                    tms_v[1] = 1'b1;
                    n = 4;
                end else begin
                    n = 3;
                end
                sh = n;
                for (int k = 0; k < len; k++) begin
                    tms_v[n] = (k == len - 1);
                    n++;
                end
                tms_v[n] = 1'b1;
                n += 2;
            end
            default: n = len;
        endcase
    endfunction

    task automatic start_cmd(input logic [1:0] cmd, input int len, input logic [MAX_LEN-1:0] data,
                             output int acc, output bit ok);
        int w = 0;
        @(negedge clk);
        while (!req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("req_ready_before_cmd", 64'(req_ready), 64'd1);
        ok  = req_ready;
        acc = 0;
        if (!ok) return;
        cmd_base  = rise_total;
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_len   = LEN_W'(len);
        req_data  = data;
        @(posedge clk);
        #1;
        acc       = cyc;
        req_valid = 1'b0;
        req_cmd   = 2'($urandom);
        req_len   = LEN_W'($urandom);
        req_data  = '1;
    endtask

    task automatic run_cmd(input logic [1:0] cmd, input int len, input logic [MAX_LEN-1:0] data,
                           input int hold, input bit junk);
        int                 n, sh, acc, got_n, waited, zeros;
        logic [63:0]        exp_tms, got_tms, rnd;
        logic [MAX_LEN-1:0] exp_data, exp_tdi, got_tdi, held;
        bit                 bad, ok;
        model(cmd, len, n, exp_tms, sh, bad);
        tdo_pat  = {$urandom, $urandom};
        exp_data = '0;
        exp_tdi  = '0;
        if (!bad && (cmd == JM_CMD_IR || cmd == JM_CMD_DR)) begin
            for (int k = 0; k < len; k++) begin
                exp_data[k] = tdo_pat[sh + k];
                exp_tdi[k]  = data[k];
            end
        end
        start_cmd(cmd, len, data, acc, ok);
        if (!ok) return;
        if (junk) begin
            rnd       = {$urandom, $urandom};
            req_valid = 1'b1;
            req_cmd   = 2'($urandom);
            req_len   = LEN_W'($urandom);
            req_data  = rnd[MAX_LEN-1:0];
        end
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!resp_valid && waited < 2000);
        check("resp_valid_arrives", 64'(resp_valid), 64'd1);
        if (!resp_valid) begin
            req_valid = 1'b0;
            return;
        end
        check("latency", 64'(cyc - acc), 64'(n * 2 * CLK_DIV));
        got_n = rise_total - cmd_base;
        check("tck_rises", 64'(got_n), 64'(n));
        got_tms = '0;
        for (int i = 0; i < got_n && i < 64; i++) got_tms[i] = tms_log[cmd_base + i];
        check("tms_sequence", got_tms, exp_tms);
        if (!bad && (cmd == JM_CMD_IR || cmd == JM_CMD_DR)) begin
            got_tdi = '0;
            for (int k = 0; k < len && sh + k < got_n; k++) got_tdi[k] = tdi_log[cmd_base + sh + k];
            check("tdi_shift", 64'(got_tdi), 64'(exp_tdi));
        end else if (!bad && cmd == JM_CMD_IDLE) begin
            zeros = 0;
            for (int i = 0; i < got_n; i++) if (!tdi_log[cmd_base + i]) zeros++;
            check("tdi_idle_ones", 64'(zeros), 64'd0);
        end
        check("resp_data", 64'(resp_data), 64'(exp_data));
        check("resp_err", 64'(resp_err), 64'(bad));
        check("done_pins_tck_tms_tdi", 64'({tck, tms, tdi}), 64'(3'b001));
        held = resp_data;
        ok   = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (!resp_valid || req_ready || resp_data !== held || tck) ok = 1'b0;
        end
        if (hold > 0) check("resp_hold", 64'(ok), 64'd1);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check("release_valid_ready_busy", 64'({resp_valid, req_ready, busy}), 64'(3'b010));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int                 acc, w, b, len;
        bit                 ok;
        logic [1:0]         cmd;
        logic [63:0]        rnd;
        logic [MAX_LEN-1:0] data;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pins_tck_tms_tdi", 64'({tck, tms, tdi}), 64'(3'b011));
        check("reset_ready", 64'(req_ready), 64'd0);
        check("reset_valid_err_busy", 64'({resp_valid, resp_err, busy}), 64'd0);
        check("reset_data", 64'(resp_data), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(req_ready), 64'd1);

        b = rise_total;
        run_cmd(JM_CMD_RESET, 0, '0, 0, 1'b0);
        check("tck_period_clk", 64'((rise_t[b + 1] - rise_t[b]) / 10), 64'(2 * CLK_DIV));

        run_cmd(JM_CMD_IR, 5, 40'h11, 0, 1'b0);
        run_cmd(JM_CMD_IR, 0, 40'h11, 20, 1'b0);
        run_cmd(JM_CMD_DR, 41, '1, 3, 1'b1);
        run_cmd(JM_CMD_IDLE, 0, '0, 0, 1'b0);
        run_cmd(JM_CMD_DR, 40, {6'h10, 32'h0, 2'b10}, 0, 1'b0);
        run_cmd(JM_CMD_IDLE, 4, '0, 0, 1'b0);
        run_cmd(JM_CMD_DR, 40, {6'h11, 32'h0, 2'b01}, 1, 1'b0);

        repeat (24) begin
            cmd = 2'($urandom_range(0, 3));
            case (cmd)
                JM_CMD_IR, JM_CMD_DR: begin
                    w   = $urandom_range(0, 9);
                    len = (w == 0) ? 0 : (w == 1) ? $urandom_range(41, 63) : $urandom_range(1, 40);
                end
                JM_CMD_IDLE: len = $urandom_range(0, 12);
                default:     len = $urandom_range(0, 63);
            endcase
            rnd  = {$urandom, $urandom};
            data = rnd[MAX_LEN-1:0];
            run_cmd(cmd, len, data, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Abort a DR scan in shift step 17 with reset
        rnd  = {$urandom, $urandom};
        data = rnd[MAX_LEN-1:0];
        start_cmd(JM_CMD_DR, 40, data, acc, ok);
        w = 0;
        while ((rise_total - cmd_base) < 20 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("reached_shift_step17", 64'((rise_total - cmd_base) >= 20), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("abort_tck_tms_tdi_valid_busy_ready", 64'({tck, tms, tdi, resp_valid, busy, req_ready}),
              64'(6'b011000));
        check("abort_data", 64'(resp_data), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_abort", 64'(req_ready), 64'd1);
        run_cmd(JM_CMD_RESET, 0, '0, 0, 1'b0);
        run_cmd(JM_CMD_IR, 5, 40'h11, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
